// File: rtl/placar_pkg.sv
// Shared types and constants for the scoreboard controller: FSM states,
// score limits, digit-enable patterns and the binary-to-BCD helper.
package placar_pkg;

  localparam int SCORE_W = 7;
  localparam int ARIT_W  = 8;
  localparam int PTS_W   = 2;

  localparam logic [ARIT_W-1:0]  PLACAR_MAX = 8'd99;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = 7'd99;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    APLICA        = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_t;

  // Active-low digit enables, one per scan index.
  localparam logic [3:0] EN_A_UNI = 4'b1110;
  localparam logic [3:0] EN_A_DEZ = 4'b1101;
  localparam logic [3:0] EN_B_UNI = 4'b1011;
  localparam logic [3:0] EN_B_DEZ = 4'b0111;

  // Highest pressed button wins.
  function automatic logic [PTS_W-1:0] pts_de(input logic [2:0] btn);
    logic [PTS_W-1:0] p;
    if (btn[2])      p = 2'd3;
    else if (btn[1]) p = 2'd2;
    else if (btn[0]) p = 2'd1;
    else             p = 2'd0;
    return p;
  endfunction

  // Returns {tens, units}; valid for inputs 0..99.
  function automatic logic [7:0] bin2bcd(input logic [SCORE_W-1:0] v);
    logic [3:0]         dez;
    logic [SCORE_W-1:0] r;
    dez = 4'd0;
    r   = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= 7'd10) begin
        r   = r - 7'd10;
        dez = dez + 4'd1;
      end
    end
    return {dez, r[3:0]};
  endfunction

endpackage

// File: rtl/placar_if.sv
// Board-side bundle of the scoreboard controller: buttons and switches in,
// scores, display scan and indicators out.
interface placar_if;
  logic [2:0] cBotoes;
  logic       chaveNP;
  logic       chaveTime;
  logic [6:0] placarA;
  logic [6:0] placarB;
  logic [3:0] digitoBCD;
  logic [3:0] escolhaDisplay;
  logic       buzzer;
  logic       led;

  modport master (
    output cBotoes, chaveNP, chaveTime,
    input  placarA, placarB, digitoBCD, escolhaDisplay, buzzer, led
  );

  modport slave (
    input  cBotoes, chaveNP, chaveTime,
    output placarA, placarB, digitoBCD, escolhaDisplay, buzzer, led
  );
endinterface

// File: rtl/placar_varredura.sv
// Display scan: prescaler, digit index, BCD split of both scores and the
// registered digit/enable pair driven to the shared 7-segment decoder.
module placar_varredura
  import placar_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic               clock,
  input  logic               nReset,
  input  logic [SCORE_W-1:0] placarA_i,
  input  logic [SCORE_W-1:0] placarB_i,
  output logic [3:0]         digitoBCD_o,
  output logic [3:0]         escolhaDisplay_o
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_FIM = PRE_W'(SCAN_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       dig_q, dig_d;
  logic [3:0]       en_q, en_d;
  logic [7:0]       bcd_a, bcd_b;

  assign bcd_a = bin2bcd(placarA_i);
  assign bcd_b = bin2bcd(placarB_i);

  // Digit and enable are both derived from the next index so they change on
  // the same edge and never show one digit's value under another's enable.
  always_comb begin
    pre_d = pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (pre_q == PRE_FIM) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
    dig_d = bcd_a[3:0];
    en_d  = EN_A_UNI;
    case (idx_d)
      2'd0: begin dig_d = bcd_a[3:0]; en_d = EN_A_UNI; end
      2'd1: begin dig_d = bcd_a[7:4]; en_d = EN_A_DEZ; end
      2'd2: begin dig_d = bcd_b[3:0]; en_d = EN_B_UNI; end
      default: begin dig_d = bcd_b[7:4]; en_d = EN_B_DEZ; end
    endcase
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pre_q <= '0;
      idx_q <= 2'd0;
      dig_q <= 4'd0;
      en_q  <= EN_A_UNI;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
      dig_q <= dig_d;
      en_q  <= en_d;
    end
  end

  assign digitoBCD_o      = dig_q;
  assign escolhaDisplay_o = en_q;

endmodule

// File: rtl/placar_controlador.sv
// Scoreboard sequencing controller: one saturating score update per button
// press, buzzer/led pulses, and display scan. Optional PLACAR_DEBOUNCE_EN.
//
// state         | meaning
// OCIOSO        | idle, waiting for a press; captures pts/team/dir
// APLICA        | one cycle: writes the selected score
// ESPERA_SOLTAR | waits for all buttons released (also the reset state)
module placar_controlador
  import placar_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int BUZZ_CYCLES = 5000
`ifdef PLACAR_DEBOUNCE_EN
  ,
  parameter int DEB_CYCLES  = 20000
`endif
) (
  input logic     clock,
  input logic     nReset,
  placar_if.slave bus
);

  localparam int BUZZ_W = $clog2(BUZZ_CYCLES + 1);

  logic [2:0]         btn_s1_q, btn_s2_q;
  logic               np_s1_q, np_s2_q;
  logic               tm_s1_q, tm_s2_q;
  logic [1:0]         prime_q;

  estado_t            estado_q;
  logic [PTS_W-1:0]   pts_q;
  logic               team_q;
  logic               dir_q;
  logic [SCORE_W-1:0] placarA_q, placarB_q;
  logic [BUZZ_W-1:0]  buzz_cnt_q, led_cnt_q;
  logic               buzz_q, led_q;

  logic               press_ok, release_ok;
  logic [SCORE_W-1:0] sel_d, nova_d;
  logic [ARIT_W-1:0]  soma_d;
  logic               sat_hi_d, sat_lo_d;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      btn_s1_q <= 3'b000;
      btn_s2_q <= 3'b000;
      np_s1_q  <= 1'b0;
      np_s2_q  <= 1'b0;
      tm_s1_q  <= 1'b0;
      tm_s2_q  <= 1'b0;
      prime_q  <= 2'b00;
    end else begin
      btn_s1_q <= bus.cBotoes;
      btn_s2_q <= btn_s1_q;
      np_s1_q  <= bus.chaveNP;
      np_s2_q  <= np_s1_q;
      tm_s1_q  <= bus.chaveTime;
      tm_s2_q  <= tm_s1_q;
      prime_q  <= {prime_q[0], 1'b1};
    end
  end

`ifdef PLACAR_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic [2:0]       deb_prev_q;
  logic [DEB_W-1:0] deb_cnt_q;
  logic             estavel;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      deb_prev_q <= 3'b000;
      deb_cnt_q  <= '0;
    end else begin
      deb_prev_q <= btn_s2_q;
      if (btn_s2_q != deb_prev_q)
        deb_cnt_q <= DEB_W'(DEB_CYCLES - 1);
      else if (deb_cnt_q != '0)
        deb_cnt_q <= deb_cnt_q - DEB_W'(1);
    end
  end

  assign estavel    = (btn_s2_q == deb_prev_q) && (deb_cnt_q == '0);
  assign press_ok   = estavel && (btn_s2_q != 3'b000);
  assign release_ok = estavel && (btn_s2_q == 3'b000);
`else
  assign press_ok   = (btn_s2_q != 3'b000);
  assign release_ok = (btn_s2_q == 3'b000);
`endif

  always_comb begin
    sel_d    = team_q ? placarB_q : placarA_q;
    soma_d   = {1'b0, sel_d} + {6'd0, pts_q};
    nova_d   = sel_d;
    sat_hi_d = 1'b0;
    sat_lo_d = 1'b0;
    if (!dir_q) begin
      if (soma_d > PLACAR_MAX) begin
        nova_d   = SCORE_MAX;
        sat_hi_d = (estado_q == APLICA);
      end else begin
        nova_d = soma_d[SCORE_W-1:0];
      end
    end else begin
      if (sel_d < {5'd0, pts_q}) begin
        nova_d   = '0;
        sat_lo_d = (estado_q == APLICA);
      end else begin
        nova_d = sel_d - {5'd0, pts_q};
      end
    end
  end

  // prime_q holds off the first release decision until the synchronizers carry
  // real board values, so a button held through reset is not mistaken as released.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      estado_q   <= ESPERA_SOLTAR;
      pts_q      <= '0;
      team_q     <= 1'b0;
      dir_q      <= 1'b0;
      placarA_q  <= '0;
      placarB_q  <= '0;
      buzz_cnt_q <= '0;
      buzz_q     <= 1'b0;
      led_cnt_q  <= '0;
      led_q      <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (press_ok && prime_q[1]) begin
            pts_q    <= pts_de(btn_s2_q);
            team_q   <= tm_s2_q;
            dir_q    <= np_s2_q;
            estado_q <= APLICA;
          end
        end
        APLICA: begin
          if (team_q) placarB_q <= nova_d;
          else        placarA_q <= nova_d;
          estado_q <= ESPERA_SOLTAR;
        end
        ESPERA_SOLTAR: begin
          if (release_ok && prime_q[1]) estado_q <= OCIOSO;
        end
        default: estado_q <= ESPERA_SOLTAR;
      endcase

      if (sat_hi_d) begin
        buzz_q     <= 1'b1;
        buzz_cnt_q <= BUZZ_W'(BUZZ_CYCLES - 1);
      end else if (buzz_cnt_q != '0) begin
        buzz_cnt_q <= buzz_cnt_q - BUZZ_W'(1);
      end else begin
        buzz_q <= 1'b0;
      end

      if (sat_lo_d) begin
        led_q     <= 1'b1;
        led_cnt_q <= BUZZ_W'(BUZZ_CYCLES - 1);
      end else if (led_cnt_q != '0) begin
        led_cnt_q <= led_cnt_q - BUZZ_W'(1);
      end else begin
        led_q <= 1'b0;
      end
    end
  end

  logic [3:0] dig_w, en_w;

  placar_varredura #(
    .SCAN_DIV (SCAN_DIV)
  ) u_varredura (
    .clock            (clock),
    .nReset           (nReset),
    .placarA_i        (placarA_q),
    .placarB_i        (placarB_q),
    .digitoBCD_o      (dig_w),
    .escolhaDisplay_o (en_w)
  );

  assign bus.placarA        = placarA_q;
  assign bus.placarB        = placarB_q;
  assign bus.digitoBCD      = dig_w;
  assign bus.escolhaDisplay = en_w;
  assign bus.buzzer         = buzz_q;
  assign bus.led            = led_q;

endmodule

// File: tb/tb_placar_controlador.sv
// Scoreboard bench for placar_controlador: stimulus pushes expected scores,
// a negedge monitor pops them whenever a score changes.
module tb_placar_controlador;

  localparam int SCAN = 4;
  localparam int BUZZ = 40;
`ifdef PLACAR_DEBOUNCE_EN
  localparam int DEB    = 6;
  localparam int HOLD   = DEB + 4;
  localparam int SETTLE = DEB + 8;
`else
  localparam int HOLD   = 2;
  localparam int SETTLE = 6;
`endif

  logic clock  = 1'b0;
  logic nReset = 1'b0;

  placar_if pif ();

  placar_controlador #(
    .SCAN_DIV    (SCAN),
    .BUZZ_CYCLES (BUZZ)
`ifdef PLACAR_DEBOUNCE_EN
    ,
    .DEB_CYCLES  (DEB)
`endif
  ) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (pif)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct { int a; int b; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int ma = 0, mb = 0;

  int prev_a = 0, prev_b = 0;
  bit prev_bz = 0, prev_ld = 0;
  int bz_cur = 0, ld_cur = 0, bz_last = 0, ld_last = 0;
  int bz_rises = 0, ld_rises = 0, bz_done = 0, ld_done = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!nReset) begin
      prev_a = 0; prev_b = 0; prev_bz = 0; prev_ld = 0; bz_cur = 0; ld_cur = 0;
    end else begin
      if (int'(pif.placarA) != prev_a || int'(pif.placarB) != prev_b) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_update: got A=%0d B=%0d required A=%0d B=%0d (cycle %0d)",
                   pif.placarA, pif.placarB, prev_a, prev_b, cyc);
        end else begin
          e = q.pop_front();
          chk("upd_placarA", int'(pif.placarA), e.a);
          chk("upd_placarB", int'(pif.placarB), e.b);
        end
      end
      prev_a = int'(pif.placarA);
      prev_b = int'(pif.placarB);
      if (pif.buzzer) begin
        if (!prev_bz) bz_rises++;
        bz_cur++;
      end else if (prev_bz) begin
        bz_last = bz_cur; bz_cur = 0; bz_done++;
      end
      prev_bz = pif.buzzer;
      if (pif.led) begin
        if (!prev_ld) ld_rises++;
        ld_cur++;
      end else if (prev_ld) begin
        ld_last = ld_cur; ld_cur = 0; ld_done++;
      end
      prev_ld = pif.led;
    end
  end

  task automatic model_press(input logic [2:0] btn);
    int p, s, n;
    exp_t e;
    p = btn[2] ? 3 : (btn[1] ? 2 : 1);
    s = pif.chaveTime ? mb : ma;
    if (!pif.chaveNP) n = (s + p > 99) ? 99 : s + p;
    else              n = (s < p) ? 0 : s - p;
    if (n != s) begin
      if (pif.chaveTime) mb = n; else ma = n;
      e.a = ma; e.b = mb;
      q.push_back(e);
    end
  endtask

  task automatic press(input logic [2:0] btn, input int hold, output int t0);
    model_press(btn);
    @(posedge clock); #1;
    pif.cBotoes = btn;
    t0 = cyc;
    repeat (hold) @(posedge clock);
    #1 pif.cBotoes = 3'b000;
    repeat (SETTLE) @(posedge clock);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clock);
    chk(nm, q.size(), 0);
  endtask

  task automatic add_to(input logic tm, input int alvo);
    int d, t;
    pif.chaveTime = tm;
    pif.chaveNP   = 1'b0;
    while ((tm ? mb : ma) < alvo) begin
      d = alvo - (tm ? mb : ma);
      press((d >= 3) ? 3'b100 : ((d == 2) ? 3'b010 : 3'b001), HOLD, t);
    end
  endtask

  initial begin
    repeat (60000) @(posedge clock);
    $display("FAIL watchdog: cycle=%0d limit=%0d", cyc, 60000);
    $fatal(1, "bench timeout");
  end

  initial begin
    int c1, c2, t, r0, d0;
    logic [3:0] last_en;
    logic [3:0] en_tab [4];
    int         dig_tab [4];
    bit         found;
    en_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dig_tab = '{7, 4, 5, 0};

    pif.cBotoes = 3'b000; pif.chaveNP = 1'b0; pif.chaveTime = 1'b0;
    repeat (3) @(posedge clock); #1;
    chk("rst_placarA", int'(pif.placarA), 0);
    chk("rst_placarB", int'(pif.placarB), 0);
    chk("rst_escolha", int'(pif.escolhaDisplay), 4'b1110);
    chk("rst_digito",  int'(pif.digitoBCD), 0);
    chk("rst_buzzer",  int'(pif.buzzer), 0);
    chk("rst_led",     int'(pif.led), 0);
    nReset = 1'b1;
    repeat (3) @(posedge clock);

    // +3 to team A held 10 cycles: one update, visible after the fourth edge
`ifndef PLACAR_DEBOUNCE_EN
    model_press(3'b100);
    @(posedge clock); #1 pif.cBotoes = 3'b100;
    repeat (3) @(posedge clock); #1;
    chk("lat_edge3_A", int'(pif.placarA), 0);
    @(posedge clock); #1;
    chk("lat_edge4_A", int'(pif.placarA), 3);
    repeat (6) @(posedge clock); #1 pif.cBotoes = 3'b000;
    repeat (SETTLE) @(posedge clock);
`else
    press(3'b100, 10, t);
`endif
    drain("t1_drain");
    chk("t1_placarB", int'(pif.placarB), 0);
    chk("t1_buzz_rises", bz_rises, 0);
    chk("t1_led_rises", ld_rises, 0);

    // team B to 98, +2 saturates, +1 at 99 restarts the buzzer
    add_to(1'b1, 98);
    drain("t2_fill");
    r0 = bz_rises; d0 = bz_done;
    press(3'b010, HOLD, c1);
    press(3'b001, HOLD, c2);
    drain("t2_drain");
    chk("t2_placarB_99", int'(pif.placarB), 99);
    for (int i = 0; i < 300 && bz_done == d0; i++) @(posedge clock);
    chk("t2_buzz_done", bz_done, d0 + 1);
    chk("t2_buzz_rises", bz_rises - r0, 1);
    chk("t2_buzz_len", bz_last, (c2 - c1) + BUZZ);

    // subtract on team A: 3-2=1, 1-3 clamps with led, 2-2 lands on 0 exactly
    pif.chaveTime = 1'b0; pif.chaveNP = 1'b1;
    press(3'b010, HOLD, t);
    r0 = ld_rises; d0 = ld_done;
    press(3'b100, HOLD, t);
    for (int i = 0; i < 300 && ld_done == d0; i++) @(posedge clock);
    chk("t3_led_done", ld_done, d0 + 1);
    chk("t3_led_len", ld_last, BUZZ);
    pif.chaveNP = 1'b0;
    press(3'b010, HOLD, t);
    pif.chaveNP = 1'b1;
    press(3'b010, HOLD, t);
    repeat (BUZZ + 5) @(posedge clock);
    chk("t3_led_exact_zero", ld_rises - r0, 1);
    chk("t3_placarA", int'(pif.placarA), 0);
    drain("t3_drain");

    // 3'b011 held 50 cycles with team switch toggled mid-hold: one +2 on A
    pif.chaveNP = 1'b0; pif.chaveTime = 1'b0;
    model_press(3'b011);
    @(posedge clock); #1 pif.cBotoes = 3'b011;
    repeat (20) @(posedge clock); #1 pif.chaveTime = 1'b1;
    repeat (10) @(posedge clock); #1 pif.chaveTime = 1'b0;
    repeat (20) @(posedge clock); #1 pif.cBotoes = 3'b000;
    repeat (SETTLE) @(posedge clock);
    drain("t4_drain");
    chk("t4_placarA", int'(pif.placarA), 2);
    chk("t4_placarB", int'(pif.placarB), 99);
    press(3'b011, HOLD, t);
    drain("t4_repress");
    chk("t4_placarA_2nd", int'(pif.placarA), 4);

    // +1 held across a reset pulse
    @(posedge clock); #1 pif.cBotoes = 3'b001;
    @(posedge clock); #1 nReset = 1'b0;
    ma = 0; mb = 0;
    #1;
    chk("t5_rst_placarA", int'(pif.placarA), 0);
    chk("t5_rst_placarB", int'(pif.placarB), 0);
    chk("t5_rst_escolha", int'(pif.escolhaDisplay), 4'b1110);
    repeat (3) @(posedge clock); #1 nReset = 1'b1;
    repeat (20) @(posedge clock); #1;
    chk("t5_held_no_inc", int'(pif.placarA), 0);
    pif.cBotoes = 3'b000;
    repeat (SETTLE) @(posedge clock);
    press(3'b001, HOLD, t);
    drain("t5_repress");
    chk("t5_placarA", int'(pif.placarA), 1);

`ifdef PLACAR_DEBOUNCE_EN
    @(posedge clock); #1 pif.cBotoes = 3'b001;
    repeat (3) @(posedge clock); #1 pif.cBotoes = 3'b000;
    repeat (SETTLE + 5) @(posedge clock);
    chk("t6_glitch", int'(pif.placarA), 1);
`endif

    // display scan with A=47, B=5
    @(posedge clock); #1 nReset = 1'b0;
    ma = 0; mb = 0;
    repeat (2) @(posedge clock); #1 nReset = 1'b1;
    repeat (3) @(posedge clock);
    add_to(1'b0, 47);
    add_to(1'b1, 5);
    drain("t7_fill");
    chk("t7_placarA", int'(pif.placarA), 47);
    chk("t7_placarB", int'(pif.placarB), 5);
    found = 1'b0;
    @(negedge clock);
    last_en = pif.escolhaDisplay;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (pif.escolhaDisplay == 4'b1110 && last_en != 4'b1110) found = 1'b1;
      last_en = pif.escolhaDisplay;
    end
    chk("t7_scan_start", int'(found), 1);
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clock);
      chk("t7_escolha", int'(pif.escolhaDisplay), int'(en_tab[(k / SCAN) % 4]));
      chk("t7_digito", int'(pif.digitoBCD), dig_tab[(k / SCAN) % 4]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
